// File: rtl/mc_pc_sequencer.sv
// mc_pc_sequencer: multi-cycle control FSM owning PC load/source, IR load, regfile and data-memory strobes.
// Optional MEM_WAIT_EN adds mem_ready so MEM can stretch until the memory responds.
module mc_pc_sequencer #(
  parameter int         CNT_W   = 32,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
`ifdef MEM_WAIT_EN
  input  logic             mem_ready,
`endif
  output logic             PCWre,
  output logic [1:0]       PCsrc,
  output logic             IRWre,
  output logic             RegWre,
  output logic             MemRd,
  output logic             MemWr,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             halted
);
  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
  } state_t;
  state_t st, nx;
  logic rdy;
`ifdef MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  assign rdy = 1'b1;
`endif
  logic is_r, is_jr, is_alu, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_halt, is_nop;
  logic is_br, is_jmp, taken;
  assign is_r    = opcode == 6'b000000;
  assign is_jr   = is_r && funct == 6'b001000;
  assign is_lw   = opcode == 6'b100011;
  assign is_sw   = opcode == 6'b101011;
  assign is_beq  = opcode == 6'b000100;
  assign is_bne  = opcode == 6'b000101;
  assign is_j    = opcode == 6'b000010;
  assign is_jal  = opcode == 6'b000011;
  assign is_halt = opcode == HALT_OP;
  assign is_alu  = (is_r && !is_jr) || opcode == 6'b001000 || opcode == 6'b001101 || opcode == 6'b001010;
  assign is_nop  = !(is_r || is_alu || is_lw || is_sw || is_beq || is_bne || is_j || is_jal || is_halt);
  assign is_br   = is_beq || is_bne;
  assign is_jmp  = is_j || is_jal || is_jr || is_nop;
  assign taken   = (is_beq && zero) || (is_bne && !zero);
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) st <= S_IF;
    else st <= nx;
  always_comb begin
    nx = S_IF;
    case (st)
      S_IF:   nx = S_ID;
      S_ID:   nx = is_jmp ? S_IF : is_halt ? S_HALT : S_EXE;
      S_EXE:  nx = is_br ? S_IF : (is_lw || is_sw) ? S_MEM : S_WB;
      S_MEM:  nx = !rdy ? S_MEM : is_lw ? S_WB : S_IF;
      S_WB:   nx = S_IF;
      S_HALT: nx = S_HALT;
      default: nx = S_IF;
    endcase
  end
  logic in_if, in_id, in_exe, in_mem, in_wb;
  assign in_if  = st == S_IF;
  assign in_id  = st == S_ID;
  assign in_exe = st == S_EXE;
  assign in_mem = st == S_MEM;
  assign in_wb  = st == S_WB;
  // Strobes are gated by Reset so an abort mid-instruction cannot leak a write.
  assign IRWre  = Reset && in_if;
  assign PCWre  = Reset && ((in_id && is_jmp) || (in_exe && is_br) || (in_mem && is_sw && rdy) || in_wb);
  assign PCsrc  = !Reset ? 2'b00 : (in_id && (is_j || is_jal)) ? 2'b10 : (in_id && is_jr) ? 2'b11 :
                  (in_exe && taken) ? 2'b01 : 2'b00;
  assign RegWre = Reset && ((in_wb && (is_alu || is_lw)) || (in_id && is_jal));
  assign MemRd  = Reset && in_mem && is_lw;
  assign MemWr  = Reset && in_mem && is_sw;
  assign state  = st;
  assign halted = st == S_HALT;
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) instr_count <= '0;
    else if (PCWre) instr_count <= instr_count + CNT_W'(1);
endmodule

// File: tb/tb_mc_pc_sequencer.sv
// tb_mc_pc_sequencer: scoreboard bench; per-instruction cycle traces are queued and compared each cycle.
module tb_mc_pc_sequencer;
  logic        CLK = 0;
  logic        Reset = 0;
  logic [5:0]  opcode = 0, funct = 0;
  logic        zero = 0;
  logic        PCWre, IRWre, RegWre, MemRd, MemWr, halted;
  logic [1:0]  PCsrc;
  logic [2:0]  state;
  logic [31:0] instr_count;
`ifdef MEM_WAIT_EN
  logic        mem_ready = 1;
  localparam int NW = 3;
`else
  localparam int NW = 0;
`endif
  mc_pc_sequencer dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .funct(funct), .zero(zero),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .PCWre(PCWre), .PCsrc(PCsrc), .IRWre(IRWre), .RegWre(RegWre), .MemRd(MemRd),
    .MemWr(MemWr), .state(state), .instr_count(instr_count), .halted(halted)
  );
  always #5 CLK = ~CLK;
  int n_chk = 0, n_pass = 0;
  logic [31:0] exp_cnt = 0;
  logic [10:0] q[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask
  function automatic logic [31:0] obs();
    return {21'd0, halted, state, IRWre, PCWre, PCsrc, RegWre, MemRd, MemWr};
  endfunction
  function automatic void put(input logic [2:0] s, input logic pcw, input logic [1:0] src,
                              input logic rw, input logic rd, input logic wr);
    q.push_back({s == 3'd5, s, s == 3'd0, pcw, src, rw, rd, wr});
  endfunction
  // Builds the expected trace for one instruction, then samples ns cycles (0 = all).
  task automatic run(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input int wt, input int ns);
    int n;
    bit full;
    @(negedge CLK);
    check({nm, "_cnt"}, instr_count, exp_cnt);
    opcode = op; funct = fn; zero = z;
    put(0, 0, 0, 0, 0, 0);
    case (op)
      6'b000000, 6'b001000, 6'b001101, 6'b001010:
        if (op == 6'b000000 && fn == 6'b001000) put(1, 1, 2'b11, 0, 0, 0);
        else begin put(1, 0, 0, 0, 0, 0); put(2, 0, 0, 0, 0, 0); put(4, 1, 0, 1, 0, 0); end
      6'b000100, 6'b000101: begin
        put(1, 0, 0, 0, 0, 0);
        put(2, 1, ((op == 6'b000100) == z) ? 2'b01 : 2'b00, 0, 0, 0);
      end
      6'b000010: put(1, 1, 2'b10, 0, 0, 0);
      6'b000011: put(1, 1, 2'b10, 1, 0, 0);
      6'b100011: begin
        put(1, 0, 0, 0, 0, 0); put(2, 0, 0, 0, 0, 0);
        for (int k = 0; k <= wt; k++) put(3, 0, 0, 0, 1, 0);
        put(4, 1, 0, 1, 0, 0);
      end
      6'b101011: begin
        put(1, 0, 0, 0, 0, 0); put(2, 0, 0, 0, 0, 0);
        for (int k = 0; k < wt; k++) put(3, 0, 0, 0, 0, 1);
        put(3, 1, 0, 0, 0, 1);
      end
      6'b111111: begin put(1, 0, 0, 0, 0, 0); for (int k = 0; k < 4; k++) put(5, 0, 0, 0, 0, 0); end
      default: put(1, 1, 0, 0, 0, 0);
    endcase
    n = q.size();
    full = (ns == 0 || ns >= n);
    if (!full) n = ns;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge CLK);
`ifdef MEM_WAIT_EN
      mem_ready = !(i >= 3 && i < 3 + wt);
`endif
      #1 check(nm, obs(), {21'd0, q.pop_front()});
    end
    q.delete();
    if (full && op != 6'b111111) exp_cnt++;
  endtask
  task automatic reset_pulse(input string nm);
    Reset = 0;
    #1 check(nm, obs(), 32'd0);
    check({nm, "_cnt"}, instr_count, 32'd0);
    exp_cnt = 0;
    @(posedge CLK);
    #1 Reset = 1;
  endtask
  initial begin
    repeat (3) @(posedge CLK);
    #1 check("rst_out", obs(), 32'd0);
    check("rst_cnt", instr_count, 32'd0);
    Reset = 1;
    run("add",  6'b000000, 6'b100000, 0, 0, 0);
    run("addi", 6'b001000, 6'b000000, 0, 0, 0);
    run("beq_t", 6'b000100, 6'b000000, 1, 0, 0);
    run("beq_n", 6'b000100, 6'b000000, 0, 0, 0);
    run("bne_t", 6'b000101, 6'b000000, 0, 0, 0);
    run("jal",  6'b000011, 6'b000000, 0, 0, 0);
    run("jr",   6'b000000, 6'b001000, 0, 0, 0);
    run("j",    6'b000010, 6'b000000, 0, 0, 0);
    run("nop",  6'b111110, 6'b000000, 0, 0, 0);
    run("lw",   6'b100011, 6'b000000, 0, 0, 0);
    run("sw",   6'b101011, 6'b000000, 0, 0, 0);
    run("lw_w", 6'b100011, 6'b000000, 0, NW, 0);
    run("sw_w", 6'b101011, 6'b000000, 0, NW, 0);
    run("halt", 6'b111111, 6'b000000, 0, 0, 0);
    check("halt_cnt", instr_count, exp_cnt);
    reset_pulse("rst_halt");
    run("ori",  6'b001101, 6'b000000, 0, 0, 0);
    run("add_abort", 6'b000000, 6'b100000, 0, 0, 3);
    reset_pulse("rst_exe");
    run("slti", 6'b001010, 6'b000000, 0, 0, 0);
    @(negedge CLK);
    check("final_cnt", instr_count, exp_cnt);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mc_pc_sequencer.md
Name: mc_pc_sequencer

Overview:
Multi-cycle control FSM that sequences instruction execution for the MIPS-subset core. It owns the next-PC update path: it decides when the PC register loads (PCWre) and which next-PC source the PC adder selects (PCsrc). It also drives IR load, register-file write and data-memory strobes. It keeps a retired-instruction counter for bring-up.

Parameters:
CNT_W, 32, width of retired-instruction counter
HALT_OP, 6'b111111, opcode that parks the FSM in HALT

Ports:
CLK  input  1  core clock; state updates on posedge
Reset  input  1  asynchronous, active-low reset
opcode  input  6  IR[31:26], stable from end of IF until next IF
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag, valid in EXE
PCWre  output  1  PC load enable
PCsrc  output  2  00 PC+4, 01 branch, 10 jump, 11 jr
IRWre  output  1  instruction register load
RegWre  output  1  register-file write enable
MemRd  output  1  data-memory read strobe
MemWr  output  1  data-memory write strobe
state  output  3  current state, for debug
instr_count  output  CNT_W  retired instructions
halted  output  1  FSM is in HALT

Behaviour:
- Reset low (async): state=IF(3'd0), instr_count=0, all strobes forced 0 while Reset low, PCsrc=00, halted=0.
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5. Codes 6,7 illegal -> next state IF.
- Decode:
  - R=000000; jr = R with funct 001000
  - addi 001000, ori 001101, slti 001010
  - lw 100011, sw 101011
  - beq 000100, bne 000101
  - j 000010, jal 000011
  - HALT_OP
  - anything else = NOP
- Transitions, one per posedge:
  - IF->ID.
  - ID: j/jal/jr/NOP->IF; HALT_OP->HALT; else->EXE.
  - EXE: beq/bne->IF; lw/sw->MEM; else->WB.
  - MEM: lw->WB; sw->IF.
  - WB->IF.
  - HALT->HALT until Reset.
- Outputs are Moore/decode combinational from state and opcode/funct/zero.
- IRWre=1 only in IF.
- PCWre=1 exactly one cycle per instruction, in its last state:
  - ID for j/jal/jr/NOP
  - EXE for beq/bne
  - MEM for sw
  - WB otherwise
  - never in HALT.
- PCsrc:
  - 10 in ID for j/jal
  - 11 in ID for jr
  - in EXE: 01 if (beq & zero) or (bne & !zero)
  - 00 in all other cases, including not-taken branches.
- RegWre=1 in WB (R except jr, addi, ori, slti, lw) and in ID for jal (link to $31). Otherwise 0.
- MemRd=1 in MEM for lw. MemWr=1 in MEM for sw. Never both.
- instr_count increments on posedge when PCWre=1. Wraps modulo 2^CNT_W.
- halted=1 iff state==HALT.
- CPI: jump/NOP 2, branch 3, sw 4, ALU 4, lw 5.
- Reset asserted mid-instruction: aborts immediately, no PCWre/RegWre/MemWr glitch. Next instruction is fetched from IF after release.

Optional Feature:
MEM_WAIT_EN
- Defined:
  - adds input mem_ready (1 bit)
  - MEM holds while mem_ready=0
  - MemRd/MemWr stay asserted while held
  - PCWre (sw) and the MEM->WB move (lw) occur only in the cycle mem_ready=1
  - Reset still aborts
- Undefined: no port; MEM lasts exactly one cycle.

Test Plan:
- Reset low 3 cycles, release -> state 0, IRWre=1, all other strobes 0, instr_count=0.
- opcode=000000 funct=100000 (add) -> states 0,1,2,4,0; PCWre high only in WB with PCsrc=00; RegWre in WB; instr_count=1.
- beq with zero=1, then beq with zero=0 -> EXE PCsrc=01 then 00; PCWre=1 in EXE both times; RegWre never set.
- jal -> ID: PCWre=1, PCsrc=10, RegWre=1; back to IF after 2 cycles. jr (funct 001000) -> PCsrc=11, RegWre=0.
- lw then sw -> lw 5 cycles (MemRd in MEM, RegWre in WB); sw 4 cycles (MemWr in MEM, PCWre in MEM); with MEM_WAIT_EN and mem_ready low 3 cycles, MEM lasts 4 cycles.
- opcode=111111 -> HALT after ID, halted=1, instr_count frozen; Reset pulse mid-EXE of a later add -> state 0, no RegWre.
